vend_fsm_multi: RTL and testbench
=================================

Name: vend_fsm_multi

Overview:
Parametrised successor to the two-product vending controller. Supports NUM_PROD products with per-product prices, a wider saturating credit register, cancel/refund, and a sequential change dispenser that returns change one coin per cycle, greedy largest-first. It sits directly behind the board-level input decode and drives the product-ready LEDs, vend strobes and change-coin outputs.

Parameters:
NUM_PROD, 4, number of selectable products (2..8)
CREDIT_W, 6, credit register width; CREDIT_MAX = 2**CREDIT_W-1
PRICES, {6'd7,6'd5,6'd3,6'd2}, packed NUM_PROD*CREDIT_W vector; product i price = PRICES[i*CREDIT_W +: CREDIT_W]; each price nonzero
TIMEOUT_CYC, 1000, idle cycles before auto-refund (used only with VEND_TIMEOUT_EN)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
coin_in  in  2  coin strobe for one cycle: 00 none, 01 = 2, 10 = 3, 11 = 4 units
buy  in  1  one-cycle purchase request
prod_sel  in  $clog2(NUM_PROD)  product index, sampled with buy
cancel  in  1  one-cycle refund request
credit  out  CREDIT_W  current credit (registered)
ready_vec  out  NUM_PROD  bit i = credit >= price i, in IDLE/CREDIT only
vend_valid  out  1  one-cycle vend strobe
vend_id  out  $clog2(NUM_PROD)  product vended; valid with vend_valid
deny  out  1  one-cycle pulse: buy with insufficient credit or invalid prod_sel
coin_reject  out  1  one-cycle pulse: coin not accepted
chg_valid  out  1  change-coin strobe
chg_coin  out  2  change coin: 01 = 1, 10 = 2, 11 = 4 units
busy  out  1  high in VEND or CHANGE
timeout  out  1  one-cycle auto-refund pulse (tied 0 without the macro)

Behaviour:
- Reset (sync): state IDLE, credit 0, all strobes 0, vend_id 0, chg_coin 00, timeout counter 0.
- States:
  - IDLE: credit == 0.
  - CREDIT: credit > 0.
  - VEND: one cycle.
  - CHANGE: dispensing.
- All outputs are registered; every pulse lasts exactly one cycle.
- Coin in IDLE/CREDIT:
  - If credit + value <= CREDIT_MAX: add the value, go to or stay in CREDIT.
  - Otherwise: credit unchanged, coin_reject asserted the next cycle.
  - Arithmetic is done CREDIT_W+1 wide for the overflow check.
- Coins in VEND/CHANGE are always rejected (coin_reject).
- Buy in IDLE/CREDIT:
  - If prod_sel < NUM_PROD and credit >= price: credit <= credit - price and enter VEND. vend_valid and vend_id are asserted during VEND, 1 cycle after buy.
  - Otherwise: deny asserted the next cycle; state and credit unchanged.
- VEND -> CHANGE if the remaining credit > 0, else -> IDLE. The remainder is always refunded; there is no multi-vend.
- Cancel in CREDIT -> CHANGE with the full credit. Cancel in IDLE, VEND or CHANGE is ignored.
- Same-cycle priority: cancel > buy > coin.
  - A coin arriving in the same cycle as an accepted or denied buy, or an accepted cancel, is rejected.
  - Buy ignored when cancel is accepted: no deny.
- CHANGE: each cycle, emit chg_valid with the largest coin (4, 2, 1) <= remaining credit, and subtract it. When credit reaches 0, go to IDLE on the following edge; chg_valid is low in IDLE.
- Buy/cancel in VEND/CHANGE: ignored, no deny.
- ready_vec is 0 while busy. busy = state in {VEND, CHANGE}.
- Reset during VEND/CHANGE: aborts immediately. Credit is lost and no further chg_valid is emitted.

Optional Feature:
VEND_TIMEOUT_EN:
- Defined: an inactivity counter counts cycles in CREDIT without an accepted coin or buy attempt, and clears on any coin/buy/cancel. When it reaches TIMEOUT_CYC-1, the block pulses timeout and enters CHANGE with the full credit. The counter clears on leaving CREDIT.
- Undefined: no counter is built, timeout is tied 0, and CREDIT persists indefinitely.

Decomposition:
- Package vend_pkg:
  - state enum (IDLE, CREDIT, VEND, CHANGE)
  - coin-code localparams (COIN_NONE, COIN_2, COIN_3, COIN_4)
  - change-code localparams (CHG_1, CHG_2, CHG_4)
  - function coin_value(code)
  - function price_of(PRICES, idx)
- Sub-module vend_change_gen: combinational greedy selector taking the remaining credit and producing chg_coin and its value. It is instantiated once in the main FSM.

Test Plan:
- coin 01, 10 (credit 5); buy prod 2 (price 5) -> vend_valid/vend_id=2 one cycle later, credit 0, back to IDLE, no chg_valid.
- coin 11, 11 (credit 8); buy prod 0 (price 2) -> vend_id=0, then chg_valid coins 4, 2 on consecutive cycles, then IDLE.
- credit 2; buy prod 3 (price 7) -> deny pulse, credit stays 2; then cancel -> chg_coin 10 once, IDLE.
- fill credit to 62; coin 11 -> coin_reject, credit 62; coin 00 idle; buy and cancel in the same cycle -> refund 4,4,...,4,2 (15x4 + 2), no vend.
- coin during CHANGE -> coin_reject, credit unaffected; reset asserted mid-CHANGE -> next cycle credit 0, chg_valid 0, state IDLE.
- VEND_TIMEOUT_EN, TIMEOUT_CYC=16: coin 10, then idle 16 cycles -> timeout pulse, chg_coin 10, chg_coin 01; repeated with a coin at cycle 10 -> counter restarts.

Source files
------------

// File: rtl/vend_pkg.sv
// vend_pkg: shared types, coin/change encodings and helpers for the vending controller.
//   vend_state_e : controller state (StIdle, StCredit, StVend, StChange)
//   COIN_*       : coin_in encodings; CHG_* : chg_coin encodings
//   coin_value() : coin code -> credit units
//   price_of()   : extract one price from a packed price vector
package vend_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StCredit,
        StVend,
        StChange
    } vend_state_e;

    localparam logic [1:0] COIN_NONE = 2'b00;
    localparam logic [1:0] COIN_2    = 2'b01;
    localparam logic [1:0] COIN_3    = 2'b10;
    localparam logic [1:0] COIN_4    = 2'b11;

    localparam logic [1:0] CHG_NONE  = 2'b00;
    localparam logic [1:0] CHG_1     = 2'b01;
    localparam logic [1:0] CHG_2     = 2'b10;
    localparam logic [1:0] CHG_4     = 2'b11;

    // Upper bounds for price_of's fixed-width argument.
    localparam int unsigned MAX_PROD     = 8;
    localparam int unsigned MAX_CREDIT_W = 16;
    localparam int unsigned MAX_PRICES_W = MAX_PROD * MAX_CREDIT_W;

    function automatic logic [2:0] coin_value(input logic [1:0] code);
        logic [2:0] val;
        case (code)
            COIN_2:  val = 3'd2;
            COIN_3:  val = 3'd3;
            COIN_4:  val = 3'd4;
            default: val = 3'd0;
        endcase
        return val;
    endfunction

    function automatic logic [MAX_CREDIT_W-1:0] price_of(input logic [MAX_PRICES_W-1:0] prices,
                                                         input int unsigned credit_w,
                                                         input int unsigned idx);
        logic [MAX_PRICES_W-1:0] shifted;
        logic [MAX_CREDIT_W-1:0] mask;
        shifted = prices >> (idx * credit_w);
        mask    = MAX_CREDIT_W'((32'd1 << credit_w) - 32'd1);
        return MAX_CREDIT_W'(shifted) & mask;
    endfunction

endpackage

// File: rtl/vend_change_gen.sv
// vend_change_gen: greedy change-coin selector (largest of 4, 2, 1 not above remaining).
//   remaining : credit still owed (CREDIT_W bits)
//   coin_code : chg_coin encoding of the selected coin, CHG_NONE when remaining is 0
//   coin_val  : value of the selected coin in credit units
module vend_change_gen
    import vend_pkg::*;
#(
    parameter int unsigned CREDIT_W = 6
) (
    input  logic [CREDIT_W-1:0] remaining,
    output logic [1:0]          coin_code,
    output logic [2:0]          coin_val
);

    always_comb begin
        coin_code = CHG_NONE;
        coin_val  = 3'd0;
        if (remaining >= CREDIT_W'(4)) begin
            coin_code = CHG_4;
            coin_val  = 3'd4;
        end else if (remaining >= CREDIT_W'(2)) begin
            coin_code = CHG_2;
            coin_val  = 3'd2;
        end else if (remaining != '0) begin
            coin_code = CHG_1;
            coin_val  = 3'd1;
        end
    end

endmodule

// File: rtl/vend_fsm_multi.sv
// vend_fsm_multi: multi-product vending controller with saturating credit, cancel/refund and a
// one-coin-per-cycle greedy change dispenser. All outputs are registered.
// Optional macro VEND_TIMEOUT_EN adds an inactivity auto-refund in CREDIT.
// Ports:
//   clk, reset (sync, active-high)
//   coin_in, buy, prod_sel, cancel          : one-cycle requests from the input decode
//   credit, ready_vec                       : current credit and per-product affordability
//   vend_valid, vend_id, deny, coin_reject  : purchase / coin result pulses
//   chg_valid, chg_coin                     : change coin strobe and coin code
//   busy, timeout                           : in VEND/CHANGE; auto-refund pulse
module vend_fsm_multi
    import vend_pkg::*;
#(
    parameter int unsigned                  NUM_PROD    = 4,
    parameter int unsigned                  CREDIT_W    = 6,
    parameter logic [NUM_PROD*CREDIT_W-1:0] PRICES      = {6'd7, 6'd5, 6'd3, 6'd2},
    parameter int unsigned                  TIMEOUT_CYC = 1000
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [1:0]                  coin_in,
    input  logic                        buy,
    input  logic [$clog2(NUM_PROD)-1:0] prod_sel,
    input  logic                        cancel,
    output logic [CREDIT_W-1:0]         credit,
    output logic [NUM_PROD-1:0]         ready_vec,
    output logic                        vend_valid,
    output logic [$clog2(NUM_PROD)-1:0] vend_id,
    output logic                        deny,
    output logic                        coin_reject,
    output logic                        chg_valid,
    output logic [1:0]                  chg_coin,
    output logic                        busy,
    output logic                        timeout
);

    localparam int unsigned     SEL_W      = $clog2(NUM_PROD);
    localparam int unsigned     SEL_N      = 1 << SEL_W;
    localparam logic [CREDIT_W:0] CREDIT_MAX = {1'b0, {CREDIT_W{1'b1}}};

    vend_state_e         state_q, state_d;
    logic [CREDIT_W-1:0] credit_q, credit_d;
    logic [NUM_PROD-1:0] ready_q, ready_d;
    logic                vend_valid_q, vend_valid_d;
    logic [SEL_W-1:0]    vend_id_q, vend_id_d;
    logic                deny_q, deny_d;
    logic                coin_reject_q, coin_reject_d;
    logic                chg_valid_q, chg_valid_d;
    logic [1:0]          chg_coin_q, chg_coin_d;
    logic                busy_q, busy_d;

    // Price table padded to a power of two so any prod_sel indexes safely.
    logic [CREDIT_W-1:0] price_tbl [SEL_N];
    always_comb begin
        for (int unsigned i = 0; i < SEL_N; i++) begin
            price_tbl[SEL_W'(i)] = (i < NUM_PROD) ?
                CREDIT_W'(price_of(MAX_PRICES_W'(PRICES), CREDIT_W, i)) : '0;
        end
    end

    logic [1:0] chg_code;
    logic [2:0] chg_val;

    vend_change_gen #(
        .CREDIT_W (CREDIT_W)
    ) u_change_gen (
        .remaining (credit_q),
        .coin_code (chg_code),
        .coin_val  (chg_val)
    );

    // Request decode; priority is cancel > buy > coin.
    logic                open_q, coin_present, sel_valid;
    logic                cancel_ok, buy_try, buy_ok, coin_ok, to_fire;
    logic [CREDIT_W-1:0] price_sel;
    logic [CREDIT_W:0]   coin_sum;

    assign open_q       = (state_q == StIdle) || (state_q == StCredit);
    assign coin_present = (coin_in != COIN_NONE);
    assign sel_valid    = (32'(prod_sel) < NUM_PROD);
    assign price_sel    = price_tbl[prod_sel];
    assign coin_sum     = {1'b0, credit_q} + (CREDIT_W+1)'(coin_value(coin_in));
    assign cancel_ok    = (state_q == StCredit) && cancel;
    assign buy_try      = open_q && buy && !cancel_ok;
    assign buy_ok       = buy_try && sel_valid && (credit_q >= price_sel);
    // Any buy in an open state (granted or denied) claims the cycle, so the coin bounces.
    assign coin_ok      = open_q && coin_present && !cancel_ok && !buy && (coin_sum <= CREDIT_MAX);

    // State and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= StIdle;
            credit_q      <= '0;
            ready_q       <= '0;
            vend_valid_q  <= 1'b0;
            vend_id_q     <= '0;
            deny_q        <= 1'b0;
            coin_reject_q <= 1'b0;
            chg_valid_q   <= 1'b0;
            chg_coin_q    <= CHG_NONE;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            credit_q      <= credit_d;
            ready_q       <= ready_d;
            vend_valid_q  <= vend_valid_d;
            vend_id_q     <= vend_id_d;
            deny_q        <= deny_d;
            coin_reject_q <= coin_reject_d;
            chg_valid_q   <= chg_valid_d;
            chg_coin_q    <= chg_coin_d;
            busy_q        <= busy_d;
        end
    end

    // Next state and credit.
    always_comb begin
        state_d  = state_q;
        credit_d = credit_q;
        case (state_q)
            StIdle, StCredit: begin
                if (cancel_ok || to_fire) begin
                    state_d = StChange;
                end else if (buy_ok) begin
                    credit_d = credit_q - price_sel;
                    state_d  = StVend;
                end else if (coin_ok) begin
                    credit_d = coin_sum[CREDIT_W-1:0];
                    state_d  = StCredit;
                end
            end
            StVend: begin
                state_d = (credit_q != '0) ? StChange : StIdle;
            end
            StChange: begin
                // The last coin goes out while credit reads 0; leave on the edge after.
                if (credit_q == '0) begin
                    state_d = StIdle;
                end else begin
                    credit_d = credit_q - CREDIT_W'(chg_val);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Next values of the registered outputs.
    always_comb begin
        vend_valid_d  = (state_d == StVend);
        vend_id_d     = buy_ok ? prod_sel : vend_id_q;
        deny_d        = buy_try && !buy_ok;
        coin_reject_d = coin_present && !coin_ok;
        chg_valid_d   = (state_q == StChange) && (credit_q != '0);
        chg_coin_d    = chg_valid_d ? chg_code : CHG_NONE;
        busy_d        = (state_d == StVend) || (state_d == StChange);
        ready_d       = '0;
        for (int unsigned i = 0; i < NUM_PROD; i++) begin
            ready_d[i] = !busy_d && (credit_d >= price_tbl[SEL_W'(i)]);
        end
    end

`ifdef VEND_TIMEOUT_EN
    localparam int unsigned       TO_W    = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TO_W-1:0]   TO_LAST = TO_W'(TIMEOUT_CYC - 1);

    logic [TO_W-1:0] to_cnt_q, to_cnt_d;
    logic            timeout_q;
    logic            activity;

    assign activity = coin_present || buy || cancel;

    always_comb begin
        to_cnt_d = '0;
        to_fire  = 1'b0;
        if ((state_q == StCredit) && !activity) begin
            if (to_cnt_q == TO_LAST) begin
                to_fire = 1'b1;
            end else begin
                to_cnt_d = to_cnt_q + TO_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            to_cnt_q  <= '0;
            timeout_q <= 1'b0;
        end else begin
            to_cnt_q  <= to_cnt_d;
            timeout_q <= to_fire;
        end
    end

    assign timeout = timeout_q;
`else
    logic unused_timeout_cyc;
    assign unused_timeout_cyc = ^TIMEOUT_CYC;
    assign to_fire = 1'b0;
    assign timeout = 1'b0;
`endif

    assign credit      = credit_q;
    assign ready_vec   = ready_q;
    assign vend_valid  = vend_valid_q;
    assign vend_id     = vend_id_q;
    assign deny        = deny_q;
    assign coin_reject = coin_reject_q;
    assign chg_valid   = chg_valid_q;
    assign chg_coin    = chg_coin_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_vend_fsm_multi.sv
// Directed bench for vend_fsm_multi (4 products, prices 2/3/5/7, 6-bit credit).
// Each step drives one cycle of requests, then checks the whole output bundle #1 after the edge.
module tb_vend_fsm_multi;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [1:0] coin_in = 2'b00;
    logic       buy = 1'b0;
    logic [1:0] prod_sel = 2'b00;
    logic       cancel = 1'b0;
    logic [5:0] credit;
    logic [3:0] ready_vec;
    logic       vend_valid;
    logic [1:0] vend_id;
    logic       deny;
    logic       coin_reject;
    logic       chg_valid;
    logic [1:0] chg_coin;
    logic       busy;
    logic       timeout;

    int vectors = 0;
    int miscompares = 0;

    vend_fsm_multi #(
        .NUM_PROD    (4),
        .CREDIT_W    (6),
        .PRICES      ({6'd7, 6'd5, 6'd3, 6'd2}),
        .TIMEOUT_CYC (16)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .coin_in     (coin_in),
        .buy         (buy),
        .prod_sel    (prod_sel),
        .cancel      (cancel),
        .credit      (credit),
        .ready_vec   (ready_vec),
        .vend_valid  (vend_valid),
        .vend_id     (vend_id),
        .deny        (deny),
        .coin_reject (coin_reject),
        .chg_valid   (chg_valid),
        .chg_coin    (chg_coin),
        .busy        (busy),
        .timeout     (timeout)
    );

    always #5 clk = ~clk;

    // Expected bundle: {credit, ready, vv, vid, deny, rej, cv, cc, busy, timeout}.
    // ready follows credit vs prices 2/3/5/7 and is 0 while busy.
    function automatic logic [19:0] ex(input int cr, input int vv, input int vid, input int dn,
                                       input int rj, input int cv, input int cc, input int bz,
                                       input int to);
        logic [3:0] r;
        r = (bz != 0) ? 4'b0000 : {cr >= 7, cr >= 5, cr >= 3, cr >= 2};
        return {6'(cr), r, 1'(vv), 2'(vid), 1'(dn), 1'(rj), 1'(cv), 2'(cc), 1'(bz), 1'(to)};
    endfunction

    task automatic chk(input string tag, input logic [19:0] exp);
        logic [19:0] obs;
        obs = {credit, ready_vec, vend_valid, vend_valid ? vend_id : 2'b00, deny, coin_reject,
               chg_valid, chg_valid ? chg_coin : 2'b00, busy, timeout};
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_bits(input string tag, input logic [1:0] obs, input logic [1:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic st(input int c, input int b, input int s, input int k,
                      input logic [19:0] exp, input string tag);
        coin_in  = 2'(c);
        buy      = 1'(b);
        prod_sel = 2'(s);
        cancel   = 1'(k);
        @(posedge clk);
        #1;
        coin_in  = 2'b00;
        buy      = 1'b0;
        cancel   = 1'b0;
        chk(tag, exp);
    endtask

    initial begin
        // Reset
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        chk("reset", ex(0, 0, 0, 0, 0, 0, 0, 0, 0));
        chk_bits("reset_vend_id", vend_id, 2'b00);
        chk_bits("reset_chg_coin", chg_coin, 2'b00);

        // Exact-price purchase, no change
        st(1, 0, 0, 0, ex(2, 0, 0, 0, 0, 0, 0, 0, 0), "t1_coin2");
        st(2, 0, 0, 0, ex(5, 0, 0, 0, 0, 0, 0, 0, 0), "t1_coin3");
        st(0, 1, 2, 0, ex(0, 1, 2, 0, 0, 0, 0, 1, 0), "t1_buy_p2");
        st(1, 1, 0, 0, ex(0, 0, 0, 0, 1, 0, 0, 0, 0), "t1_vend_ignore");
        st(0, 0, 0, 1, ex(0, 0, 0, 0, 0, 0, 0, 0, 0), "t1_cancel_idle");

        // Purchase with change 4 then 2; coin with buy is rejected
        st(3, 0, 0, 0, ex(4, 0, 0, 0, 0, 0, 0, 0, 0), "t2_coin4a");
        st(3, 0, 0, 0, ex(8, 0, 0, 0, 0, 0, 0, 0, 0), "t2_coin4b");
        st(1, 1, 0, 0, ex(6, 1, 0, 0, 1, 0, 0, 1, 0), "t2_buy_p0");
        st(0, 0, 0, 0, ex(6, 0, 0, 0, 0, 0, 0, 1, 0), "t2_enter_chg");
        st(0, 0, 0, 0, ex(2, 0, 0, 0, 0, 1, 3, 1, 0), "t2_chg4");
        st(0, 0, 0, 0, ex(0, 0, 0, 0, 0, 1, 2, 1, 0), "t2_chg2");
        st(0, 0, 0, 0, ex(0, 0, 0, 0, 0, 0, 0, 0, 0), "t2_idle");

        // Denied buy, then cancel refund
        st(1, 0, 0, 0, ex(2, 0, 0, 0, 0, 0, 0, 0, 0), "t3_coin2");
        st(0, 1, 3, 0, ex(2, 0, 0, 1, 0, 0, 0, 0, 0), "t3_deny");
        st(0, 0, 0, 1, ex(2, 0, 0, 0, 0, 0, 0, 1, 0), "t3_cancel");
        st(0, 0, 0, 0, ex(0, 0, 0, 0, 0, 1, 2, 1, 0), "t3_chg2");
        st(0, 0, 0, 0, ex(0, 0, 0, 0, 0, 0, 0, 0, 0), "t3_idle");

        // Fill to 62, overflow reject, cancel beats buy and coin
        for (int i = 1; i <= 15; i++) st(3, 0, 0, 0, ex(4 * i, 0, 0, 0, 0, 0, 0, 0, 0), "t4_fill");
        st(1, 0, 0, 0, ex(62, 0, 0, 0, 0, 0, 0, 0, 0), "t4_62");
        st(3, 0, 0, 0, ex(62, 0, 0, 0, 1, 0, 0, 0, 0), "t4_overflow");
        st(0, 0, 0, 0, ex(62, 0, 0, 0, 0, 0, 0, 0, 0), "t4_nocoin");
        st(1, 1, 0, 1, ex(62, 0, 0, 0, 1, 0, 0, 1, 0), "t4_cancel_buy");
        for (int i = 1; i <= 15; i++)
            st(0, 0, 0, 0, ex(62 - 4 * i, 0, 0, 0, 0, 1, 3, 1, 0), "t4_chg4");
        st(0, 0, 0, 0, ex(0, 0, 0, 0, 0, 1, 2, 1, 0), "t4_chg2");
        st(0, 0, 0, 0, ex(0, 0, 0, 0, 0, 0, 0, 0, 0), "t4_idle");

        // Coin during CHANGE, then reset mid-CHANGE
        st(3, 0, 0, 0, ex(4, 0, 0, 0, 0, 0, 0, 0, 0), "t5_coin4a");
        st(3, 0, 0, 0, ex(8, 0, 0, 0, 0, 0, 0, 0, 0), "t5_coin4b");
        st(0, 0, 0, 1, ex(8, 0, 0, 0, 0, 0, 0, 1, 0), "t5_cancel");
        st(2, 0, 0, 0, ex(4, 0, 0, 0, 1, 1, 3, 1, 0), "t5_coin_in_chg");
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        chk("t5_reset_abort", ex(0, 0, 0, 0, 0, 0, 0, 0, 0));
        st(0, 0, 0, 0, ex(0, 0, 0, 0, 0, 0, 0, 0, 0), "t5_after_reset");

        // Exactly CREDIT_MAX accepted, one more rejected, buy priciest product
        for (int i = 1; i <= 15; i++) st(3, 0, 0, 0, ex(4 * i, 0, 0, 0, 0, 0, 0, 0, 0), "t6_fill");
        st(2, 0, 0, 0, ex(63, 0, 0, 0, 0, 0, 0, 0, 0), "t6_max");
        st(1, 0, 0, 0, ex(63, 0, 0, 0, 1, 0, 0, 0, 0), "t6_max_reject");
        st(0, 1, 3, 0, ex(56, 1, 3, 0, 0, 0, 0, 1, 0), "t6_buy_p3");
        st(0, 0, 0, 0, ex(56, 0, 0, 0, 0, 0, 0, 1, 0), "t6_enter_chg");
        for (int i = 1; i <= 14; i++)
            st(0, 0, 0, 0, ex(56 - 4 * i, 0, 0, 0, 0, 1, 3, 1, 0), "t6_chg4");
        st(0, 0, 0, 0, ex(0, 0, 0, 0, 0, 0, 0, 0, 0), "t6_idle");

`ifdef VEND_TIMEOUT_EN
        // Auto-refund after 16 idle cycles in CREDIT
        st(2, 0, 0, 0, ex(3, 0, 0, 0, 0, 0, 0, 0, 0), "t7_coin3");
        for (int i = 0; i < 15; i++) st(0, 0, 0, 0, ex(3, 0, 0, 0, 0, 0, 0, 0, 0), "t7_wait");
        st(0, 0, 0, 0, ex(3, 0, 0, 0, 0, 0, 0, 1, 1), "t7_timeout");
        st(0, 0, 0, 0, ex(1, 0, 0, 0, 0, 1, 2, 1, 0), "t7_chg2");
        st(0, 0, 0, 0, ex(0, 0, 0, 0, 0, 1, 1, 1, 0), "t7_chg1");
        st(0, 0, 0, 0, ex(0, 0, 0, 0, 0, 0, 0, 0, 0), "t7_idle");
        // A coin part-way through restarts the count
        st(2, 0, 0, 0, ex(3, 0, 0, 0, 0, 0, 0, 0, 0), "t8_coin3");
        for (int i = 0; i < 9; i++) st(0, 0, 0, 0, ex(3, 0, 0, 0, 0, 0, 0, 0, 0), "t8_wait_a");
        st(1, 0, 0, 0, ex(5, 0, 0, 0, 0, 0, 0, 0, 0), "t8_coin2");
        for (int i = 0; i < 15; i++) st(0, 0, 0, 0, ex(5, 0, 0, 0, 0, 0, 0, 0, 0), "t8_wait_b");
        st(0, 0, 0, 0, ex(5, 0, 0, 0, 0, 0, 0, 1, 1), "t8_timeout");
        st(0, 0, 0, 0, ex(1, 0, 0, 0, 0, 1, 3, 1, 0), "t8_chg4");
        st(0, 0, 0, 0, ex(0, 0, 0, 0, 0, 1, 1, 1, 0), "t8_chg1");
        st(0, 0, 0, 0, ex(0, 0, 0, 0, 0, 0, 0, 0, 0), "t8_idle");
`else
        // Without the timeout feature CREDIT persists
        st(2, 0, 0, 0, ex(3, 0, 0, 0, 0, 0, 0, 0, 0), "t7_coin3");
        for (int i = 0; i < 40; i++) st(0, 0, 0, 0, ex(3, 0, 0, 0, 0, 0, 0, 0, 0), "t7_hold");
        st(0, 0, 0, 1, ex(3, 0, 0, 0, 0, 0, 0, 1, 0), "t7_cancel");
        st(0, 0, 0, 0, ex(1, 0, 0, 0, 0, 1, 2, 1, 0), "t7_chg2");
        st(0, 0, 0, 0, ex(0, 0, 0, 0, 0, 1, 1, 1, 0), "t7_chg1");
        st(0, 0, 0, 0, ex(0, 0, 0, 0, 0, 0, 0, 0, 0), "t7_idle");
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
